// File: rtl/palette_dac_writer.sv
// VGA-DAC-style palette writer: an index register plus a data register that
// collects R, G, B writes and emits one registered palette write per entry.
module palette_dac_writer #(
    parameter int DAC_BITS    = 6,
    parameter bit BLANK_GATED = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bus_wr,
    input  logic       bus_addr,
    input  logic [7:0] bus_data,
    output logic       bus_ready,
    input  logic       blank,
    output logic       write_enable,
    output logic [7:0] write_index,
    output logic [3:0] write_r,
    output logic [3:0] write_g,
    output logic [3:0] write_b,
    output logic [7:0] cur_index,
    output logic [1:0] phase
);

    localparam logic [1:0] PH_R    = 2'd0;
    localparam logic [1:0] PH_G    = 2'd1;
    localparam logic [1:0] PH_B    = 2'd2;
    localparam logic [1:0] PH_PEND = 2'd3;

    logic [3:0] red_q;
    logic [3:0] green_q;
    logic [3:0] nibble;
    logic       accept;
    logic       unused_bits;

    // Only the top four bits of the DAC-width field are significant.
    assign nibble      = bus_data[DAC_BITS-1 -: 4];
    assign accept      = bus_wr && bus_ready;
    assign unused_bits = ^bus_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= PH_R;
            cur_index    <= 8'd0;
            red_q        <= 4'd0;
            green_q      <= 4'd0;
            write_enable <= 1'b0;
            write_index  <= 8'd0;
            write_r      <= 4'd0;
            write_g      <= 4'd0;
            write_b      <= 4'd0;
            bus_ready    <= 1'b1;
        end else begin
            write_enable <= 1'b0;
            if (phase == PH_PEND) begin
                // Held entry leaves on the first blanking cycle.
                if (blank) begin
                    write_enable <= 1'b1;
                    phase        <= PH_R;
                    bus_ready    <= 1'b1;
                end
            end else if (accept) begin
                if (!bus_addr) begin
                    cur_index <= bus_data;
                    phase     <= PH_R;
                    red_q     <= 4'd0;
                    green_q   <= 4'd0;
                end else begin
                    case (phase)
                        PH_R: begin
                            red_q <= nibble;
                            phase <= PH_G;
                        end
                        PH_G: begin
                            green_q <= nibble;
                            phase   <= PH_B;
                        end
                        default: begin
                            write_index <= cur_index;
                            write_r     <= red_q;
                            write_g     <= green_q;
                            write_b     <= nibble;
                            cur_index   <= cur_index + 8'd1;
                            if (BLANK_GATED) begin
                                phase     <= PH_PEND;
                                bus_ready <= 1'b0;
                            end else begin
                                write_enable <= 1'b1;
                                phase        <= PH_R;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_palette_dac_writer.sv
// Bench for palette_dac_writer: three instances (default, blank-gated, 8-bit DAC)
// checked against an entry-level reference model.
module tb_palette_dac_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       bus_wr       [3];
    logic       bus_addr     [3];
    logic [7:0] bus_data     [3];
    logic       blank        [3];
    logic       bus_ready    [3];
    logic       write_enable [3];
    logic [7:0] write_index  [3];
    logic [3:0] write_r      [3];
    logic [3:0] write_g      [3];
    logic [3:0] write_b      [3];
    logic [7:0] cur_index    [3];
    logic [1:0] phase        [3];

    palette_dac_writer #(.DAC_BITS(6), .BLANK_GATED(1'b0)) u_def (
        .clk(clk), .reset(reset), .bus_wr(bus_wr[0]), .bus_addr(bus_addr[0]),
        .bus_data(bus_data[0]), .bus_ready(bus_ready[0]), .blank(blank[0]),
        .write_enable(write_enable[0]), .write_index(write_index[0]),
        .write_r(write_r[0]), .write_g(write_g[0]), .write_b(write_b[0]),
        .cur_index(cur_index[0]), .phase(phase[0]));

    palette_dac_writer #(.DAC_BITS(6), .BLANK_GATED(1'b1)) u_gate (
        .clk(clk), .reset(reset), .bus_wr(bus_wr[1]), .bus_addr(bus_addr[1]),
        .bus_data(bus_data[1]), .bus_ready(bus_ready[1]), .blank(blank[1]),
        .write_enable(write_enable[1]), .write_index(write_index[1]),
        .write_r(write_r[1]), .write_g(write_g[1]), .write_b(write_b[1]),
        .cur_index(cur_index[1]), .phase(phase[1]));

    palette_dac_writer #(.DAC_BITS(8), .BLANK_GATED(1'b0)) u_dac8 (
        .clk(clk), .reset(reset), .bus_wr(bus_wr[2]), .bus_addr(bus_addr[2]),
        .bus_data(bus_data[2]), .bus_ready(bus_ready[2]), .blank(blank[2]),
        .write_enable(write_enable[2]), .write_index(write_index[2]),
        .write_r(write_r[2]), .write_g(write_g[2]), .write_b(write_b[2]),
        .cur_index(cur_index[2]), .phase(phase[2]));

    int checks   = 0;
    int failures = 0;

    int dac_bits [3] = '{6, 6, 8};
    bit gated    [3] = '{1'b0, 1'b1, 1'b0};

    // Reference model: count of collected components, a pending flag and the last entry.
    int          m_cnt    [3];
    bit          m_pend   [3];
    logic [7:0]  m_cur    [3];
    logic [3:0]  m_r      [3];
    logic [3:0]  m_g      [3];
    logic        m_we     [3];
    logic [7:0]  m_widx   [3];
    logic [11:0] m_wrgb   [3];
    int          m_pulses [3] = '{0, 0, 0};
    int          seen     [3] = '{0, 0, 0};

    function automatic logic [3:0] nib(input int d, input logic [7:0] v);
        logic [7:0] s;
        s = v >> (dac_bits[d] - 4);
        return s[3:0];
    endfunction

    task automatic model_update();
        for (int d = 0; d < 3; d++) begin
            if (reset) begin
                m_cnt[d] = 0; m_pend[d] = 1'b0; m_cur[d] = 8'd0; m_r[d] = 4'd0; m_g[d] = 4'd0;
                m_we[d] = 1'b0; m_widx[d] = 8'd0; m_wrgb[d] = 12'd0;
            end else begin
                m_we[d] = 1'b0;
                if (m_pend[d]) begin
                    if (blank[d]) begin
                        m_pend[d] = 1'b0; m_we[d] = 1'b1; m_pulses[d]++;
                    end
                end else if (bus_wr[d]) begin
                    if (bus_addr[d] == 1'b0) begin
                        m_cur[d] = bus_data[d]; m_cnt[d] = 0;
                    end else if (m_cnt[d] == 0) begin
                        m_r[d] = nib(d, bus_data[d]); m_cnt[d] = 1;
                    end else if (m_cnt[d] == 1) begin
                        m_g[d] = nib(d, bus_data[d]); m_cnt[d] = 2;
                    end else begin
                        m_widx[d] = m_cur[d];
                        m_wrgb[d] = {m_r[d], m_g[d], nib(d, bus_data[d])};
                        m_cur[d]  = m_cur[d] + 8'd1;
                        m_cnt[d]  = 0;
                        if (gated[d]) m_pend[d] = 1'b1;
                        else begin
                            m_we[d] = 1'b1; m_pulses[d]++;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: model follows the edge, outputs are observed on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            if (write_enable[d] === 1'b1) seen[d]++;
    endtask

    task automatic host_wr(input int d, input logic a, input logic [7:0] v);
        bus_wr[d] = 1'b1; bus_addr[d] = a; bus_data[d] = v;
        tick();
        bus_wr[d] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        reset = 1'b1;
        bus_wr[0] = 1'b1; bus_addr[0] = 1'b0; bus_data[0] = 8'hAB;
        tick();
        tick();
        bus_wr[0] = 1'b0;
        for (int d = 0; d < 3; d++) begin
            got = {bus_ready[d], write_enable[d], write_index[d], write_r[d], write_g[d],
                   write_b[d], cur_index[d], phase[d]};
            checks++;
            if (got !== 32'h8000_0000) begin
                failures++;
                $display("[TB] FAIL reset_state[%0d]: got %h expected %h", d, got, 32'h8000_0000);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_entry();
        logic [30:0] got;
        host_wr(0, 1'b0, 8'h10);
        host_wr(0, 1'b1, 8'h3F);
        host_wr(0, 1'b1, 8'h20);
        checks++;
        if ({write_enable[0], phase[0]} !== 3'b0_10) begin
            failures++;
            $display("[TB] FAIL basic_before_b: got %b expected %b", {write_enable[0], phase[0]}, 3'b0_10);
        end
        host_wr(0, 1'b1, 8'h04);
        got = {write_enable[0], write_index[0], write_r[0], write_g[0], write_b[0], cur_index[0], phase[0]};
        checks++;
        if (got !== {1'b1, 8'h10, 12'hF81, 8'h11, 2'd0}) begin
            failures++;
            $display("[TB] FAIL basic_entry: got %h expected %h", got, {1'b1, 8'h10, 12'hF81, 8'h11, 2'd0});
        end
        tick();
        checks++;
        if ({write_enable[0], write_index[0]} !== {1'b0, 8'h10}) begin
            failures++;
            $display("[TB] FAIL basic_single_pulse: got %h expected %h", {write_enable[0], write_index[0]}, {1'b0, 8'h10});
        end
    endtask

    task automatic test_wrap();
        logic [7:0] seq [3];
        int n = 0;
        int start;
        host_wr(0, 1'b0, 8'hFE);
        start = seen[0];
        for (int i = 0; i < 9; i++) begin
            host_wr(0, 1'b1, 8'($urandom));
            checks++;
            if (write_enable[0] !== m_we[0]) begin
                failures++;
                $display("[TB] FAIL wrap_we[%0d]: got %b expected %b", i, write_enable[0], m_we[0]);
            end
            if (write_enable[0] === 1'b1) begin
                if (n < 3) seq[n] = write_index[0];
                n++;
                checks++;
                if ({write_r[0], write_g[0], write_b[0]} !== m_wrgb[0]) begin
                    failures++;
                    $display("[TB] FAIL wrap_rgb: got %h expected %h", {write_r[0], write_g[0], write_b[0]}, m_wrgb[0]);
                end
            end
        end
        checks++;
        if (n != 3 || seen[0] - start != 3) begin
            failures++;
            $display("[TB] FAIL wrap_pulses: got %0d expected 3", seen[0] - start);
        end else if ({seq[0], seq[1], seq[2], cur_index[0]} !== 32'hFEFF_0001) begin
            failures++;
            $display("[TB] FAIL wrap_sequence: got %h expected %h", {seq[0], seq[1], seq[2], cur_index[0]}, 32'hFEFF_0001);
        end
    endtask

    task automatic test_index_mid_entry();
        int start;
        host_wr(0, 1'b0, 8'h05);
        host_wr(0, 1'b1, 8'h3F);
        host_wr(0, 1'b1, 8'h3F);
        start = seen[0];
        host_wr(0, 1'b0, 8'h09);
        host_wr(0, 1'b1, 8'h00);
        host_wr(0, 1'b1, 8'h00);
        host_wr(0, 1'b1, 8'h00);
        checks++;
        if ({write_enable[0], write_index[0], write_r[0], write_g[0], write_b[0]} !== {1'b1, 8'h09, 12'h000}) begin
            failures++;
            $display("[TB] FAIL index_mid_entry: got %h expected %h",
                     {write_enable[0], write_index[0], write_r[0], write_g[0], write_b[0]}, {1'b1, 8'h09, 12'h000});
        end
        tick();
        checks++;
        if (seen[0] - start != 1) begin
            failures++;
            $display("[TB] FAIL index_mid_pulses: got %0d expected 1", seen[0] - start);
        end
    endtask

    task automatic test_blank_gating();
        int bad = 0;
        blank[1] = 1'b0;
        host_wr(1, 1'b0, 8'h03);
        host_wr(1, 1'b1, 8'h3C);
        host_wr(1, 1'b1, 8'h08);
        host_wr(1, 1'b1, 8'h14);
        checks++;
        if ({phase[1], bus_ready[1], write_enable[1]} !== 4'b11_0_0) begin
            failures++;
            $display("[TB] FAIL gate_pending: got %b expected %b", {phase[1], bus_ready[1], write_enable[1]}, 4'b1100);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (write_enable[1] !== 1'b0) bad++;
        end
        host_wr(1, 1'b1, 8'h3F);
        checks++;
        if (bad != 0 || {phase[1], cur_index[1], write_index[1], write_r[1], write_g[1], write_b[1]} !== {2'd3, 8'h04, 8'h03, 12'hF25}) begin
            failures++;
            $display("[TB] FAIL gate_hold: got %0d pulses, state %h expected %h", bad,
                     {phase[1], cur_index[1], write_index[1], write_r[1], write_g[1], write_b[1]}, {2'd3, 8'h04, 8'h03, 12'hF25});
        end
        blank[1] = 1'b1;
        tick();
        checks++;
        if ({write_enable[1], bus_ready[1], phase[1], write_index[1], write_r[1], write_g[1], write_b[1]} !== {1'b1, 1'b1, 2'd0, 8'h03, 12'hF25}) begin
            failures++;
            $display("[TB] FAIL gate_release: got %h expected %h",
                     {write_enable[1], bus_ready[1], phase[1], write_index[1], write_r[1], write_g[1], write_b[1]},
                     {1'b1, 1'b1, 2'd0, 8'h03, 12'hF25});
        end
        tick();
        checks++;
        if (write_enable[1] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL gate_single_pulse: got %b expected 0", write_enable[1]);
        end
        host_wr(1, 1'b0, 8'h07);
        host_wr(1, 1'b1, 8'h00);
        host_wr(1, 1'b1, 8'h00);
        host_wr(1, 1'b1, 8'h00);
        checks++;
        if ({write_enable[1], phase[1]} !== 3'b0_11) begin
            failures++;
            $display("[TB] FAIL gate_blank_latency1: got %b expected %b", {write_enable[1], phase[1]}, 3'b011);
        end
        tick();
        checks++;
        if ({write_enable[1], write_index[1]} !== {1'b1, 8'h07}) begin
            failures++;
            $display("[TB] FAIL gate_blank_latency2: got %h expected %h", {write_enable[1], write_index[1]}, {1'b1, 8'h07});
        end
        blank[1] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int start;
        host_wr(0, 1'b0, 8'h40);
        host_wr(0, 1'b1, 8'h3F);
        host_wr(0, 1'b1, 8'h3F);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        host_wr(0, 1'b1, 8'h3C);
        host_wr(0, 1'b1, 8'h3C);
        host_wr(0, 1'b1, 8'h3C);
        checks++;
        if ({write_enable[0], write_index[0], write_r[0], write_g[0], write_b[0], cur_index[0]} !== {1'b1, 8'h00, 12'hFFF, 8'h01}) begin
            failures++;
            $display("[TB] FAIL reset_mid_entry: got %h expected %h",
                     {write_enable[0], write_index[0], write_r[0], write_g[0], write_b[0], cur_index[0]}, {1'b1, 8'h00, 12'hFFF, 8'h01});
        end
        blank[1] = 1'b0;
        host_wr(1, 1'b0, 8'h20);
        host_wr(1, 1'b1, 8'h11);
        host_wr(1, 1'b1, 8'h22);
        host_wr(1, 1'b1, 8'h33);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        blank[1] = 1'b1;
        start = seen[1];
        repeat (5) tick();
        checks++;
        if (seen[1] - start != 0 || {phase[1], bus_ready[1]} !== 3'b00_1) begin
            failures++;
            $display("[TB] FAIL reset_drops_pending: got %0d pulses phase %0d ready %b expected 0 pulses phase 0 ready 1",
                     seen[1] - start, phase[1], bus_ready[1]);
        end
        blank[1] = 1'b0;
    endtask

    task automatic test_dac8();
        host_wr(2, 1'b0, 8'h80);
        host_wr(2, 1'b1, 8'hA5);
        host_wr(2, 1'b1, 8'h5A);
        host_wr(2, 1'b1, 8'hF0);
        checks++;
        if ({write_enable[2], write_index[2], write_r[2], write_g[2], write_b[2]} !== {1'b1, 8'h80, 12'hA5F}) begin
            failures++;
            $display("[TB] FAIL dac8_nibbles: got %h expected %h",
                     {write_enable[2], write_index[2], write_r[2], write_g[2], write_b[2]}, {1'b1, 8'h80, 12'hA5F});
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] exp;
        for (int c = 0; c < 600; c++) begin
            for (int d = 0; d < 3; d++) begin
                bus_wr[d]   = ($urandom_range(0, 3) != 0);
                bus_addr[d] = ($urandom_range(0, 9) != 0);
                bus_data[d] = 8'($urandom);
                blank[d]    = ($urandom_range(0, 3) == 0);
            end
            reset = ($urandom_range(0, 99) == 0);
            tick();
            for (int d = 0; d < 3; d++) begin
                got = {bus_ready[d], write_enable[d], phase[d], cur_index[d], write_index[d],
                       write_r[d], write_g[d], write_b[d]};
                exp = {~m_pend[d], m_we[d], (m_pend[d] ? 2'd3 : 2'(m_cnt[d])), m_cur[d], m_widx[d], m_wrgb[d]};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("[TB] FAIL random[%0d] cycle %0d: got %h expected %h", d, c, got, exp);
                end
            end
        end
        reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            bus_wr[d] = 1'b0;
            blank[d]  = 1'b0;
        end
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (seen[d] != m_pulses[d]) begin
                failures++;
                $display("[TB] FAIL pulse_total[%0d]: got %0d expected %0d", d, seen[d], m_pulses[d]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            bus_wr[d] = 1'b0; bus_addr[d] = 1'b0; bus_data[d] = 8'h00; blank[d] = 1'b0;
        end
        test_reset();
        test_basic_entry();
        test_wrap();
        test_index_mid_entry();
        test_blank_gating();
        test_reset_mid();
        test_dac8();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
